// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   mem_size_e    : access size encoding as carried on req_size
//   state_e       : responder FSM states
//   size_bytes    : number of bytes touched by an access of a given size
//   is_misaligned : natural-alignment check on the byte offset within a doubleword
package data_mem_pkg;

  localparam int unsigned XLEN_DEF   = 64;
  localparam int unsigned ADDR_W_DEF = 64;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_WR,
    ST_RMW_ISSUE,
    ST_RMW_WAIT,
    ST_RMW_WR,
    ST_RESP
  } state_e;

  function automatic logic [3:0] size_bytes(input mem_size_e size);
    return 4'd1 << size;
  endfunction

  function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] off);
    case (size)
      SZ_H:    return off[0] != 1'b0;
      SZ_W:    return off[1:0] != 2'b00;
      SZ_D:    return off != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the control FSM (master) and the
// data-memory responder (slave).
//   req_valid/req_write/req_size/req_unsigned/req_addr/req_wdata : request
//   req_ready                                                    : responder idle
//   resp_valid/resp_rdata/resp_misaligned                        : completion pulse
interface data_mem_responder_if #(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned ADDR_W = 64
);
  logic              req_valid;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              req_ready;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_misaligned;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misaligned
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misaligned
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for the data-memory responder.
//   word     : RAM doubleword as read
//   off      : byte offset within the doubleword (little-endian)
//   size     : access size
//   uns      : zero-extend loads when set, sign-extend otherwise
//   wdata    : store data, low bytes used for sub-word stores
//   load_val : selected lane, extended to XLEN
//   merged   : word with bytes off..off+size-1 replaced from wdata
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      off,
  input  mem_size_e       size,
  input  logic            uns,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_val,
  output logic [XLEN-1:0] merged
);

  logic [XLEN-1:0] shifted;
  int unsigned     off_i;
  int unsigned     end_i;

  assign shifted = word >> {off, 3'b000};
  assign off_i   = 32'(off);
  assign end_i   = 32'(off) + 32'(size_bytes(size));

  always_comb begin
    load_val = shifted;
    case (size)
      SZ_B:    load_val = {{(XLEN-8){~uns & shifted[7]}},  shifted[7:0]};
      SZ_H:    load_val = {{(XLEN-16){~uns & shifted[15]}}, shifted[15:0]};
      SZ_W:    load_val = {{(XLEN-32){~uns & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  // Byte i of the RAM word takes wdata byte (i - off) when inside the access window.
  always_comb begin
    merged = word;
    for (int unsigned i = 0; i < XLEN / 8; i++) begin
      if (i >= off_i && i < end_i) begin
        merged[8*i +: 8] = wdata[8*(i - off_i) +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the multicycle control unit's data strobes.
// Accepts one load/store at a time, drives a synchronous 64-bit RAM, and
// returns a single-cycle completion pulse.
//   CLK, RST   : clock, asynchronous active-high reset
//   bus        : request/response bundle (slave side)
//   mem_addr   : doubleword-aligned RAM address, 0 while idle
//   mem_wr     : RAM write enable, one cycle per store
//   mem_wdata  : RAM write data, 0 outside write states
//   mem_rdata  : RAM read data, valid the cycle after a read address
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                    CLK,
  input  logic                    RST,
  data_mem_responder_if.slave     bus,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_wr,
  output logic [XLEN-1:0]         mem_wdata,
  input  logic [XLEN-1:0]         mem_rdata
);

  state_e            st, st_nxt;
  logic [ADDR_W-1:0] addr_q;
  mem_size_e         size_q;
  logic              write_q;
  logic              uns_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic [XLEN-1:0]   merged_q;
  logic              mis_q;

  mem_size_e         size_in;
  logic              accept;
  logic              mis_in;
  logic [XLEN-1:0]   load_val;
  logic [XLEN-1:0]   merged;

  assign size_in = mem_size_e'(bus.req_size);
  assign accept  = (st == ST_IDLE) && bus.req_valid;
  assign mis_in  = is_misaligned(size_in, bus.req_addr[2:0]);

  mem_lane_align #(.XLEN(XLEN)) u_align (
    .word     (mem_rdata),
    .off      (addr_q[2:0]),
    .size     (size_q),
    .uns      (uns_q),
    .wdata    (wdata_q),
    .load_val (load_val),
    .merged   (merged)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st <= ST_IDLE;
    end else begin
      st <= st_nxt;
    end
  end

  always_comb begin
    st_nxt = st;
    case (st)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (mis_in)              st_nxt = ST_RESP;
          else if (!bus.req_write) st_nxt = ST_RD_ISSUE;
          else if (size_in == SZ_D) st_nxt = ST_WR;
          else                     st_nxt = ST_RMW_ISSUE;
        end
      end
      ST_RD_ISSUE:  st_nxt = ST_RD_WAIT;
      ST_RD_WAIT:   st_nxt = ST_RESP;
      ST_WR:        st_nxt = ST_RESP;
      ST_RMW_ISSUE: st_nxt = ST_RMW_WAIT;
      ST_RMW_WAIT:  st_nxt = ST_RMW_WR;
      ST_RMW_WR:    st_nxt = ST_RESP;
      ST_RESP:      st_nxt = ST_IDLE;
      default:      st_nxt = ST_IDLE;
    endcase
  end

  // Request latch plus response/merge registers. resp_rdata is cleared on
  // accept so stores and misaligned accesses report 0, and otherwise holds.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q   <= '0;
      size_q   <= SZ_B;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      merged_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        size_q  <= size_in;
        write_q <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        wdata_q <= bus.req_wdata;
        rdata_q <= '0;
        mis_q   <= mis_in;
      end
      if (st == ST_RD_WAIT)  rdata_q  <= load_val;
      if (st == ST_RMW_WAIT) merged_q <= merged;
    end
  end

  always_comb begin
    bus.req_ready       = 1'b0;
    bus.resp_valid      = 1'b0;
    bus.resp_misaligned = 1'b0;
    bus.resp_rdata      = rdata_q;
    mem_addr            = {addr_q[ADDR_W-1:3], 3'b000};
    mem_wr              = 1'b0;
    mem_wdata           = '0;
    case (st)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        mem_addr      = '0;
      end
      ST_WR: begin
        mem_wr    = 1'b1;
        mem_wdata = wdata_q;
      end
      ST_RMW_WR: begin
        mem_wr    = 1'b1;
        mem_wdata = merged_q;
      end
      ST_RESP: begin
        bus.resp_valid      = 1'b1;
        bus.resp_misaligned = mis_q;
      end
      default: ;
    endcase
  end

  logic unused_write_q;
  assign unused_write_q = write_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed requests push expected
// responses and RAM writes; a negedge monitor pops and compares them.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [63:0] mem_addr;
  logic        mem_wr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic [63:0] ram [0:31];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [63:0] rdata;
    logic        mis;
    int          at;
    string       name;
  } resp_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    string       name;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  resp_t r;
  wr_t   w;

  data_mem_responder_if #(.XLEN(64), .ADDR_W(64)) bus ();

  data_mem_responder #(.XLEN(64), .ADDR_W(64)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (mem_wr) ram[mem_addr[7:3]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:3]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.resp_valid) begin
      if (rq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
      end else begin
        r = rq.pop_front();
        check({r.name, "_rdata"}, bus.resp_rdata, r.rdata);
        check({r.name, "_mis"}, 64'(bus.resp_misaligned), 64'(r.mis));
        check({r.name, "_latency"}, 64'(cyc), 64'(r.at));
      end
    end
    if (mem_wr) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr: got mem_wr addr %h data %h expected none", mem_addr, mem_wdata);
      end else begin
        w = wq.pop_front();
        check({w.name, "_waddr"}, mem_addr, w.addr);
        check({w.name, "_wdata"}, mem_wdata, w.data);
      end
    end
  end

  // lat counts edges from the accept edge (inclusive) to entering RESP.
  task automatic issue(input string name, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [63:0] exp, input logic mis, input int lat,
                       input logic wexp, input logic [63:0] wdexp);
    int n;
    n = 0;
    @(negedge CLK);
    while (!bus.req_ready && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check({name, "_ready_in"}, 64'(bus.req_ready), 64'd1);
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    if (wexp) wq.push_back('{{addr[63:3], 3'b000}, wdexp, name});
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    rq.push_back('{exp, mis, cyc + lat - 1, name});
    check({name, "_ready_busy"}, 64'(bus.req_ready), 64'd0);
    n = 0;
    while (rq.size() != 0 && n < 20) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (rq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no response expected one", name);
      rq.delete();
    end
    check({name, "_wq_empty"}, 64'(wq.size()), 64'd0);
    wq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = 64'h0;
    ram[5'h02] = 64'h00000000_000080FF;
    ram[5'h04] = 64'h11223344_55667788;
    ram[5'h06] = 64'h01234567_89ABCDEF;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;

    repeat (2) @(negedge CLK);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_mis", 64'(bus.resp_misaligned), 64'd0);
    check("rst_mem_wr", 64'(mem_wr), 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_rdata", bus.resp_rdata, 64'd0);
    RST = 1'b0;

    issue("lb_11",   1'b0, 2'b00, 1'b0, 64'h11, 64'h0, 64'hFFFFFFFFFFFFFF80, 1'b0, 3, 1'b0, 64'h0);
    issue("lhu_10",  1'b0, 2'b01, 1'b1, 64'h10, 64'h0, 64'h00000000000080FF, 1'b0, 3, 1'b0, 64'h0);
    issue("lw_14",   1'b0, 2'b10, 1'b0, 64'h14, 64'h0, 64'h0,                1'b0, 3, 1'b0, 64'h0);
    issue("lh_10",   1'b0, 2'b01, 1'b0, 64'h10, 64'h0, 64'hFFFFFFFFFFFF80FF, 1'b0, 3, 1'b0, 64'h0);
    issue("sb_23",   1'b1, 2'b00, 1'b0, 64'h23, 64'hAB, 64'h0, 1'b0, 4, 1'b1, 64'h11223344AB667788);
    issue("ld_20",   1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 64'h11223344AB667788, 1'b0, 3, 1'b0, 64'h0);
    issue("sd_28",   1'b1, 2'b11, 1'b0, 64'h28, 64'hDEADBEEFCAFEF00D, 64'h0, 1'b0, 2, 1'b1, 64'hDEADBEEFCAFEF00D);
    issue("ld_28",   1'b0, 2'b11, 1'b0, 64'h28, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 3, 1'b0, 64'h0);
    issue("lw_22",   1'b0, 2'b10, 1'b0, 64'h22, 64'h0, 64'h0, 1'b1, 1, 1'b0, 64'h0);
    @(negedge CLK);
    check("lw_22_ready_after", 64'(bus.req_ready), 64'd1);
    issue("sd_2c",   1'b1, 2'b11, 1'b0, 64'h2C, 64'h5A5A5A5A5A5A5A5A, 64'h0, 1'b1, 1, 1'b0, 64'h0);
    issue("ldu_28",  1'b0, 2'b11, 1'b1, 64'h28, 64'h0, 64'hDEADBEEFCAFEF00D, 1'b0, 3, 1'b0, 64'h0);
    issue("lbu_2f",  1'b0, 2'b00, 1'b1, 64'h2F, 64'h0, 64'h00000000000000DE, 1'b0, 3, 1'b0, 64'h0);
    issue("sw_2c",   1'b1, 2'b10, 1'b0, 64'h2C, 64'hFFFFFFFF12345678, 64'h0, 1'b0, 4, 1'b1, 64'h12345678CAFEF00D);
    issue("ld_28b",  1'b0, 2'b11, 1'b0, 64'h28, 64'h0, 64'h12345678CAFEF00D, 1'b0, 3, 1'b0, 64'h0);

    // Abort a halfword RMW while it sits in RMW_WAIT.
    @(negedge CLK);
    bus.req_write    = 1'b1;
    bus.req_size     = 2'b01;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'h30;
    bus.req_wdata    = 64'h5555;
    bus.req_valid    = 1'b1;
    @(posedge CLK);
    #1;
    bus.req_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK);
    check("abort_mem_wr", 64'(mem_wr), 64'd0);
    check("abort_ready_in_rst", 64'(bus.req_ready), 64'd1);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("abort_ready", 64'(bus.req_ready), 64'd1);
    check("abort_ram30", ram[5'h06], 64'h0123456789ABCDEF);
    check("abort_mem_addr", mem_addr, 64'd0);
    issue("ld_30",   1'b0, 2'b11, 1'b0, 64'h30, 64'h0, 64'h0123456789ABCDEF, 1'b0, 3, 1'b0, 64'h0);

    repeat (2) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder to the multicycle control unit's data-memory strobes.
- Accepts one load/store request at a time from the datapath/control FSM and drives a synchronous 64-bit data RAM.
- For loads: selects the byte/half/word/double lane, then sign- or zero-extends it.
- For stores: writes doublewords directly; sub-word stores use read-modify-write. Returns a single-cycle response pulse.

Parameters:
- XLEN, 64, data width of register file and RAM word.
- ADDR_W, 64, byte-address width.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request strobe, sampled only when req_ready=1.
- req_write  in  1  1=store, 0=load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 double.
- req_unsigned  in  1  loads only: 1=zero-extend, 0=sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data; low bytes used for sub-word stores.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- resp_misaligned  out  1  qualifies resp_valid: access was misaligned and not performed.
- mem_addr  out  ADDR_W  doubleword-aligned address {req_addr[ADDR_W-1:3],3'b000}.
- mem_wr  out  1  RAM write enable.
- mem_wdata  out  XLEN  RAM write data.
- mem_rdata  in  XLEN  RAM read data, valid the cycle after mem_addr is presented with mem_wr=0.

Behaviour:
- Reset: state IDLE. req_ready=1. resp_valid, resp_misaligned, mem_wr=0. resp_rdata, mem_addr, mem_wdata=0. Latched request fields cleared.
- Accept: IDLE & req_valid at a rising edge latches addr/size/write/unsigned/wdata. The request inputs are ignored in every other state.
- Misalignment:
  - half with addr[0]≠0, word with addr[1:0]≠0, or double with addr[2:0]≠0.
  - Goes IDLE→RESP directly, with resp_misaligned=1 and resp_rdata=0.
  - No mem_wr and no RAM read. Latency from accept edge is 1 cycle.
- States:
  - IDLE
  - RD_ISSUE: mem_addr driven, mem_wr=0.
  - RD_WAIT: capture extracted mem_rdata into the response register.
  - WR: mem_wr=1 for exactly one cycle.
  - RMW_ISSUE
  - RMW_WAIT: merge latched bytes into mem_rdata and register the merged word.
  - RMW_WR: mem_wr=1 with the merged word.
  - RESP: resp_valid=1, then back to IDLE.
- Transitions:
  - load: IDLE→RD_ISSUE→RD_WAIT→RESP→IDLE (resp_valid 3 cycles after the accept edge).
  - store double: IDLE→WR→RESP→IDLE (resp_valid 2 cycles after accept).
  - store sub-word: IDLE→RMW_ISSUE→RMW_WAIT→RMW_WR→RESP→IDLE (resp_valid 4 cycles after accept).
- Lane select: byte offset off=addr[2:0], little-endian. The lane is mem_rdata[8*off +: 8·bytes].
- Extension: the MSB of the lane replicates to XLEN unless unsigned. Unsigned on a double is a no-op.
- Merge: only bytes off..off+bytes-1 are replaced, taken from wdata[8·bytes-1:0]. All other bytes are preserved from mem_rdata.
- Output hold:
  - mem_addr holds the latched aligned address in every non-IDLE state and 0 in IDLE.
  - mem_wdata is 0 outside WR/RMW_WR.
- No backpressure on the response: the consumer must sample it in the RESP cycle. resp_rdata is held until the next accept.
- req_valid asserted during RESP is not accepted. The earliest next accept is the IDLE cycle after RESP.
- RST mid-operation: returns to IDLE at once.
  - mem_wr drops asynchronously; no partial RMW write completes.
  - No resp_valid is issued for the aborted request.

Decomposition:
- Package data_mem_pkg holds:
  - enum mem_size_e {SZ_B, SZ_H, SZ_W, SZ_D}
  - the state enum
  - XLEN default
  - function size_bytes(size)
  - function is_misaligned(size, off)
- Sub-module mem_lane_align: purely combinational. Inputs: mem word, off, size, unsigned, wdata. Outputs: extracted/extended load value and merged store word. The FSM instantiates it once.

Test Plan:
- Load signed byte: RAM[0x10]=0x8877665544332211_80… use word 0x00000000_000080FF at 0x10; ld byte 0x11 signed → resp_rdata=0xFFFFFFFFFFFFFF80, resp_valid 3 cycles after accept.
- Load unsigned half: same word, half at 0x10 unsigned → resp_rdata=0x00000000000080FF; word load at 0x14 signed → 0x0.
- Store byte RMW: RAM[0x20]=0x1122334455667788; sb wdata=0xAB at 0x23 → exactly one mem_wr with mem_wdata=0x11223344AB667788; resp_valid 4 cycles after accept.
- Store double: sd 0xDEADBEEFCAFEF00D at 0x28 → mem_wr one cycle, mem_addr=0x28, resp_valid 2 cycles after accept; a following ld at 0x28 returns the same value.
- Misaligned: word load at 0x22 → resp_valid+resp_misaligned 1 cycle after accept, resp_rdata=0, no mem_wr, req_ready back to 1 the next cycle.
- Reset mid-RMW: assert RST in RMW_WAIT for sh at 0x30 → no mem_wr ever, no resp_valid, RAM[0x30] unchanged, req_ready=1 after release.
